// File: rtl/spm_port_arbiter_pkg.sv
// Shared types and constants for the scratch-pad port B arbiter.
// State encoding, default sizes and direction/enable encodings.
package spm_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int N_REQ_DEF  = 2;
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

  localparam logic READ    = 1'b1;
  localparam logic WRITE   = 1'b0;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // Width of a requester index; at least one bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spm_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr,
// searching upward modulo N_REQ. Returns one-hot and index forms.
module rr_arbiter
  import spm_port_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int PW    = ptr_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    idx,
  output logic             valid
);

  logic [PW:0]   s;
  logic [PW-1:0] j;

  // Walk the N_REQ candidates starting at ptr; first hit wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    s     = '0;
    j     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      s = {1'b0, ptr} + (PW+1)'(k);
      if (s >= (PW+1)'(N_REQ)) s = s - (PW+1)'(N_REQ);
      j = s[PW-1:0];
      if (!valid && req[j]) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/spm_port_arbiter.sv
// Shares SPM port B between N_REQ requesters: round-robin pick in IDLE,
// one RAM access cycle, then a DONE cycle with rdy and read data.
module spm_port_arbiter
  import spm_port_arbiter_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        rw,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  input  logic [N_REQ*DATA_W-1:0] wr_data,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        rdy,
  output logic [DATA_W-1:0]       rd_data,
  output logic [ADDR_W-1:0]       spm_addr,
  output logic [DATA_W-1:0]       spm_wr_data,
  output logic                    spm_we,
  input  logic [DATA_W-1:0]       spm_rd_data
);

  localparam int PW = ptr_w(N_REQ);

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  rdy_q, rdy_d;
  logic [PW-1:0]     win_q, win_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic              rd_op_q, rd_op_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  logic [N_REQ-1:0]  arb_gnt;
  logic [PW-1:0]     arb_idx;
  logic              arb_valid;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr (
    .req   (req),
    .ptr   (rr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Next-state and next-output logic for the 3-cycle access sequence.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rdy_d   = '0;
    we_d    = DISABLE;
    win_d   = win_q;
    rr_d    = rr_q;
    rd_op_d = rd_op_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = ACCESS;
          grant_d = arb_gnt;
          win_d   = arb_idx;
          rd_op_d = (rw[arb_idx] == READ);
          we_d    = (rw[arb_idx] == WRITE) ? ENABLE : DISABLE;
          addr_d  = addr[arb_idx*ADDR_W +: ADDR_W];
          wd_d    = wr_data[arb_idx*DATA_W +: DATA_W];
        end
      end
      ACCESS: begin
        state_d = DONE;
        rdy_d   = grant_q;
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        addr_d  = '0;
        wd_d    = '0;
        if (rd_op_q) hold_d = spm_rd_data;
        if (win_q == PW'(N_REQ-1)) rr_d = '0;
        else rr_d = win_q + PW'(1);
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      rdy_q   <= '0;
      win_q   <= '0;
      rr_q    <= '0;
      rd_op_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rdy_q   <= rdy_d;
      win_q   <= win_d;
      rr_q    <= rr_d;
      rd_op_q <= rd_op_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      hold_q  <= hold_d;
    end
  end

  // RAM read data lands in DONE; pass it straight through in that cycle.
  always_comb begin
    rd_data = hold_q;
    if (state_q == DONE && rd_op_q) rd_data = spm_rd_data;
  end

  assign grant       = grant_q;
  assign rdy         = rdy_q;
  assign spm_addr    = addr_q;
  assign spm_wr_data = wd_q;
  assign spm_we      = we_q;

endmodule

// File: tb/tb_spm_port_arbiter.sv
// Bench for spm_port_arbiter: vector table, corner sequences,
// random traffic against a transaction-level model, and an N_REQ=4 case.
module tb_spm_port_arbiter;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = '0, rw = '0;
  logic [23:0] addr = '0;
  logic [63:0] wr_data = '0;
  logic [1:0]  grant, rdy;
  logic [31:0] rd_data, spm_wr_data, spm_rd_data;
  logic [11:0] spm_addr;
  logic        spm_we;

  logic [3:0]   req4 = '0;
  logic [3:0]   rw4 = 4'hF;
  logic [47:0]  addr4 = '0;
  logic [127:0] wd4 = '0;
  logic [3:0]   grant4, rdy4;
  logic [31:0]  rd4, swd4;
  logic [31:0]  srd4 = '0;
  logic [11:0]  sa4;
  logic         swe4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  spm_port_arbiter #(.N_REQ(2), .ADDR_W(12), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .req(req), .rw(rw), .addr(addr),
    .wr_data(wr_data), .grant(grant), .rdy(rdy), .rd_data(rd_data),
    .spm_addr(spm_addr), .spm_wr_data(spm_wr_data), .spm_we(spm_we),
    .spm_rd_data(spm_rd_data)
  );

  spm_port_arbiter #(.N_REQ(4), .ADDR_W(12), .DATA_W(32)) dut4 (
    .clk(clk), .reset(reset), .req(req4), .rw(rw4), .addr(addr4),
    .wr_data(wd4), .grant(grant4), .rdy(rdy4), .rd_data(rd4),
    .spm_addr(sa4), .spm_wr_data(swd4), .spm_we(swe4),
    .spm_rd_data(srd4)
  );

  // RAM port B stand-in: registered read, 1-cycle latency.
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (spm_we) mem[spm_addr] <= spm_wr_data;
    spm_rd_data <= mem[spm_addr];
  end

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  task automatic set_in(input int i, input logic r, input logic w,
                        input logic [11:0] a, input logic [31:0] d);
    req[i] = r;
    rw[i] = w;
    addr[i*12 +: 12] = a;
    wr_data[i*32 +: 32] = d;
  endtask

  typedef struct {
    logic [1:0]  req, rw;
    logic [11:0] a0, a1;
    logic [31:0] d0, d1;
    logic [1:0]  eg;
    logic        ewe;
    logic [11:0] ea;
    logic [31:0] ewd;
    logic        crd;
    logic [31:0] erd;
  } vec_t;

  vec_t vt [8];

  // model state for random traffic
  int ph, win, ptr;
  bit rdop;
  bit found;
  logic [11:0] ma;
  logic [31:0] mw;
  logic [31:0] mmem [int];
  bit pend [2];
  logic [1:0] eg, er;
  logic ewe;

  initial begin
    vt[0] = '{2'b01, 2'b00, 12'h010, 12'h000, 32'hDEADBEEF, 32'h0,
              2'b01, 1'b1, 12'h010, 32'hDEADBEEF, 1'b0, 32'h0};
    vt[1] = '{2'b10, 2'b00, 12'h000, 12'h0FF, 32'h0, 32'h12345678,
              2'b10, 1'b1, 12'h0FF, 32'h12345678, 1'b0, 32'h0};
    vt[2] = '{2'b01, 2'b11, 12'h010, 12'h000, 32'h0, 32'h0,
              2'b01, 1'b0, 12'h010, 32'h0, 1'b1, 32'hDEADBEEF};
    vt[3] = '{2'b11, 2'b11, 12'h010, 12'h0FF, 32'h0, 32'h0,
              2'b10, 1'b0, 12'h0FF, 32'h0, 1'b1, 32'h12345678};
    vt[4] = '{2'b11, 2'b11, 12'h010, 12'h0FF, 32'h0, 32'h0,
              2'b01, 1'b0, 12'h010, 32'h0, 1'b1, 32'hDEADBEEF};
    vt[5] = '{2'b01, 2'b10, 12'h020, 12'h000, 32'hA5A5A5A5, 32'h0,
              2'b01, 1'b1, 12'h020, 32'hA5A5A5A5, 1'b0, 32'h0};
    vt[6] = '{2'b01, 2'b10, 12'h030, 12'h000, 32'h33333333, 32'h0,
              2'b01, 1'b1, 12'h030, 32'h33333333, 1'b0, 32'h0};
    vt[7] = '{2'b10, 2'b11, 12'h000, 12'h0FF, 32'h0, 32'h0,
              2'b10, 1'b0, 12'h0FF, 32'h0, 1'b1, 32'h12345678};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_out", 64'({grant, rdy, spm_we, spm_addr}), 64'(0));
    chk("rst_data", 64'({rd_data, spm_wr_data}), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // contention from rr_ptr=0: 01,10,01,10, no gaps
    req = 2'b11;
    rw = 2'b11;
    for (int c = 0; c < 12; c++) begin
      logic [1:0] g;
      if (c > 0) @(negedge clk);
      g = (c % 3 == 0) ? 2'b00 : (((c / 3) % 2 == 1) ? 2'b10 : 2'b01);
      chk("cont_grant", 64'(grant), 64'(g));
      chk("cont_rdy", 64'(rdy), 64'((c % 3 == 2) ? g : 2'b00));
      if (c == 11) req = 2'b00;
    end
    @(negedge clk);

    // table of single transactions
    for (int v = 0; v < 8; v++) begin
      set_in(0, vt[v].req[0], vt[v].rw[0], vt[v].a0, vt[v].d0);
      set_in(1, vt[v].req[1], vt[v].rw[1], vt[v].a1, vt[v].d1);
      @(negedge clk);
      chk("vec_grant", 64'(grant), 64'(vt[v].eg));
      chk("vec_we", 64'(spm_we), 64'(vt[v].ewe));
      chk("vec_addr", 64'(spm_addr), 64'(vt[v].ea));
      chk("vec_wd", 64'(spm_wr_data), 64'(vt[v].ewd));
      req = 2'b00;
      @(negedge clk);
      chk("vec_rdy", 64'({grant, rdy, spm_we}), 64'({vt[v].eg, vt[v].eg, 1'b0}));
      if (vt[v].crd) chk("vec_rd", 64'(rd_data), 64'(vt[v].erd));
      @(negedge clk);
      chk("vec_idle", 64'({grant, rdy, spm_we}), 64'(0));
    end

    // late change of addr and dropped req after grant
    set_in(0, 1'b1, 1'b1, 12'h020, 32'h0);
    @(negedge clk);
    chk("late_grant", 64'(grant), 64'(2'b01));
    set_in(0, 1'b0, 1'b1, 12'h030, 32'h0);
    @(negedge clk);
    chk("late_rdy", 64'(rdy), 64'(2'b01));
    chk("late_addr", 64'(spm_addr), 64'(12'h020));
    chk("late_rd", 64'(rd_data), 64'(32'hA5A5A5A5));
    @(negedge clk);

    // reset during a write access
    set_in(1, 1'b1, 1'b0, 12'h040, 32'h00000077);
    @(negedge clk);
    chk("rsta_we", 64'({grant, spm_we}), 64'({2'b10, 1'b1}));
    #2 reset = 1'b1;
    #1;
    chk("rsta_async", 64'({grant, rdy, spm_we}), 64'(0));
    @(negedge clk);
    req = 2'b00;
    reset = 1'b0;
    @(negedge clk);
    chk("rsta_idle", 64'({grant, rdy, spm_we, spm_addr}), 64'(0));
    chk("rsta_data", 64'({rd_data, spm_wr_data}), 64'(0));
    req = 2'b11;
    rw = 2'b11;
    @(negedge clk);
    chk("rsta_ptr", 64'(grant), 64'(2'b01));
    req = 2'b00;
    repeat (2) @(negedge clk);

    // random traffic vs transaction model
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ph = 0;
    win = 0;
    ptr = 0;
    rdop = 1'b0;
    ma = '0;
    mw = '0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      eg = (ph != 0) ? 2'(1 << win) : 2'b00;
      er = (ph == 2) ? eg : 2'b00;
      ewe = (ph == 1) && !rdop;
      chk("rnd_ctl", 64'({grant, rdy, spm_we}), 64'({eg, er, ewe}));
      if (ph == 1) chk("rnd_addr", 64'(spm_addr), 64'(ma));
      if (ph == 1 && !rdop) chk("rnd_wd", 64'(spm_wr_data), 64'(mw));
      if (ph == 2 && rdop && mmem.exists(int'(ma)))
        chk("rnd_rd", 64'(rd_data), 64'(mmem[int'(ma)]));
      for (int i = 0; i < N; i++) begin
        if (ph == 2 && win == i) pend[i] = 1'b0;
        if (!pend[i]) begin
          if ($urandom_range(0, 2) != 0) begin
            pend[i] = 1'b1;
            set_in(i, 1'b1, 1'($urandom_range(0, 1)),
                   12'($urandom_range(0, 15)), $urandom);
          end else begin
            req[i] = 1'b0;
          end
        end else if (ph != 0 && win == i && $urandom_range(0, 3) == 0) begin
          addr[i*12 +: 12] = 12'($urandom_range(0, 15));
          wr_data[i*32 +: 32] = $urandom;
        end
      end
      if (ph == 0) begin
        if (req != 2'b00) begin
          found = 1'b0;
          for (int k = 0; k < N; k++) begin
            if (!found && req[(ptr + k) % N]) begin
              found = 1'b1;
              win = (ptr + k) % N;
            end
          end
          rdop = rw[win];
          ma = addr[win*12 +: 12];
          mw = wr_data[win*32 +: 32];
          ph = 1;
        end
      end else if (ph == 1) begin
        if (!rdop) mmem[int'(ma)] = mw;
        ph = 2;
      end else begin
        ph = 0;
        ptr = (win + 1) % N;
      end
    end
    req = 2'b00;

    // N_REQ=4: serve 1 to move ptr to 2, then 1010 -> 3 then 1
    @(negedge clk);
    req4 = 4'b0010;
    @(negedge clk);
    chk("n4_g1", 64'(grant4), 64'(4'b0010));
    req4 = 4'b0000;
    @(negedge clk);
    chk("n4_r1", 64'(rdy4), 64'(4'b0010));
    req4 = 4'b1010;
    @(negedge clk);
    chk("n4_idle", 64'(grant4), 64'(4'b0000));
    @(negedge clk);
    chk("n4_g3", 64'(grant4), 64'(4'b1000));
    @(negedge clk);
    chk("n4_r3", 64'(rdy4), 64'(4'b1000));
    repeat (2) @(negedge clk);
    chk("n4_g1b", 64'(grant4), 64'(4'b0010));
    req4 = 4'b0000;
    @(negedge clk);
    chk("n4_r1b", 64'(rdy4), 64'(4'b0010));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
